// File: rtl/seq_mult_pkg.sv
// Shared types and helpers for the iterative shift-add multiplier.
package seq_mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Edges from acceptance to out_valid; one multiplier bit per edge.
  function automatic int mult_latency(input int width);
    return width;
  endfunction

  // p holds a zero-extended 2*width-bit product.
  function automatic logic mult_ovf(input logic [63:0] p, input int width, input logic sgn);
    logic [63:0] hi;
    logic [63:0] mask;
    if (sgn) begin
      hi   = p >> (width - 1);
      mask = (64'd1 << (width + 1)) - 64'd1;
      return !((hi == 64'd0) || (hi == mask));
    end else begin
      hi = p >> width;
      return hi != 64'd0;
    end
  endfunction

endpackage

// File: rtl/twos_abs_neg.sv
// Conditional two's-complement negate: magnitude on the way in, sign restore on the way out.
module twos_abs_neg #(
  parameter int W = 8
) (
  input  logic [W-1:0] x,
  input  logic         neg,
  output logic [W-1:0] y
);

  assign y = neg ? -x : x;

endmodule

// File: rtl/seq_mult.sv
// Iterative WIDTH-cycle shift-add multiplier, signed or unsigned per operation,
// with valid/ready handshakes on operand and result sides.
module seq_mult
  import seq_mult_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               is_signed,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               ovf
);

  localparam int         LAT  = mult_latency(WIDTH);
  localparam [CNT_W-1:0] LAST = CNT_W'(LAT - 1);

  // Handshake: a transfer happens on a rising edge where valid && ready;
  // producers hold valid and data until that edge.
  state_t               state;
  logic [CNT_W-1:0]     cnt;
  logic [2*WIDTH-1:0]   acc;
  logic [2*WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]     mplier;
  logic                 neg_q;
  logic                 sgn_q;

  logic [WIDTH-1:0]     abs_a;
  logic [WIDTH-1:0]     abs_b;
  logic [2*WIDTH-1:0]   acc_next;
  logic [2*WIDTH-1:0]   p_next;
  logic                 load;

  twos_abs_neg #(.W(WIDTH)) u_abs_a (
    .x   (a),
    .neg (is_signed & a[WIDTH-1]),
    .y   (abs_a)
  );

  twos_abs_neg #(.W(WIDTH)) u_abs_b (
    .x   (b),
    .neg (is_signed & b[WIDTH-1]),
    .y   (abs_b)
  );

  assign acc_next = mplier[0] ? (acc + mcand) : acc;

  twos_abs_neg #(.W(2 * WIDTH)) u_neg_p (
    .x   (acc_next),
    .neg (neg_q),
    .y   (p_next)
  );

  assign in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
  assign out_valid = (state == DONE);
  assign load      = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      neg_q   <= 1'b0;
      sgn_q   <= 1'b0;
      product <= '0;
      ovf     <= 1'b0;
    end else if (load) begin
      // Also covers the DONE hand-off: the old result retires on this edge.
      sgn_q  <= is_signed;
      neg_q  <= is_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
      mcand  <= {{WIDTH{1'b0}}, abs_a};
      mplier <= abs_b;
      acc    <= '0;
      cnt    <= '0;
      state  <= BUSY;
    end else begin
      case (state)
        BUSY: begin
          acc    <= acc_next;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + CNT_W'(1);
          if (cnt == LAST) begin
            product <= p_next;
            ovf     <= mult_ovf(64'(p_next), WIDTH, sgn_q);
            state   <= DONE;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/seq_mult.md
Name: seq_mult

Overview:
Parametrised iterative shift-add multiplier for WIDTH-bit operands.
- Supports unsigned and two's-complement signed operation, selected per operation.
- Returns the full 2*WIDTH-bit product plus an overflow flag for WIDTH-bit truncation.
- Replaces the fixed 8-bit combinational multiplier where area matters more than latency.
- Sits between operand producers and result consumers, with valid/ready handshakes on both sides.

Parameters:
WIDTH, 8, operand width in bits; legal range 2..32.
CNT_W, $clog2(WIDTH+1), iteration counter width; derived, not overridden.

Ports:
clk  in  1  clock; all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  operand pair and mode valid
in_ready  out  1  block can accept operands this cycle
a  in  WIDTH  multiplicand
b  in  WIDTH  multiplier
is_signed  in  1  1 = two's-complement operands, 0 = unsigned
out_valid  out  1  product valid
out_ready  in  1  consumer accepts product
product  out  2*WIDTH  full product
ovf  out  1  product does not fit in WIDTH bits (signed or unsigned, per captured mode)

Behaviour:
Reset (async assert, sync release):
- state=IDLE, counter=0, out_valid=0, product=0, ovf=0, all internal registers=0.
- in_ready is 1 the first cycle after release.

States: IDLE, BUSY, DONE.
- in_ready = (state==IDLE) || (state==DONE && out_ready).
- out_valid = (state==DONE).

Acceptance (in_valid && in_ready at rising edge):
- Capture is_signed.
- Capture |a| and |b| (magnitudes when is_signed=1, raw values otherwise).
- Capture neg = is_signed && (a[WIDTH-1] ^ b[WIDTH-1]).
- Clear the accumulator, counter=0, state goes to BUSY.
- Captured values are held; later input changes have no effect.

BUSY (one multiplier bit per cycle, LSB first):
- If multiplier bit = 1, add the shifted multiplicand into the 2*WIDTH accumulator.
- Counter increments each cycle.
- On the edge completing iteration WIDTH-1:
  - product = neg ? -acc : acc (2*WIDTH-bit two's complement).
  - ovf is computed from that product.
  - state goes to DONE.
- Latency: out_valid rises exactly WIDTH edges after the acceptance edge.

Overflow rule:
- Unsigned: ovf = |product[2W-1:W].
- Signed: ovf = 1 unless product[2W-1:W-1] is all 0s or all 1s.

Magnitude edge case:
- The most negative operand (-2^(W-1)) has magnitude 2^(W-1), which fits in WIDTH bits unsigned.
- No special case is needed.

DONE:
- product and ovf are held stable while out_valid=1 && out_ready=0 (backpressure; no limit on duration).
- out_ready=1, in_valid=0: go to IDLE; out_valid drops next cycle.
- out_ready=1, in_valid=1 in the same cycle: result retires and new operands are accepted on the same edge; go directly to BUSY.
- Sustained throughput: one result per WIDTH+1 cycles.

Other rules:
- in_valid in BUSY is ignored (in_ready=0); the producer must hold it.
- Reset asserted mid-operation aborts immediately: no out_valid, all outputs return to reset values.
- Zero operands are not skipped early; latency is always WIDTH.

Decomposition:
Shared package seq_mult_pkg holds:
- the state enum (IDLE/BUSY/DONE);
- the latency function mult_latency(WIDTH)=WIDTH;
- the overflow helper function.

One natural sub-module: twos_abs_neg, parametrised by width. It provides conditional magnitude on input and conditional negate on output, and is instantiated three times: a, b, and product.

The datapath and FSM stay in seq_mult.

Test Plan:
All scenarios use WIDTH=8.

1. Unsigned 200*3 (a=0xC8, b=0x03, is_signed=0) -> after 8 edges out_valid=1, product=0x0258, ovf=1.
2. Unsigned 15*17 -> product=0x00FF, ovf=0. Also 0*0xFF -> product=0x0000, ovf=0, latency still 8.
3. Signed -3*5 (a=0xFD, b=0x05) -> product=0xFFF1, ovf=0. Signed -128*-128 (0x80, 0x80) -> product=0x4000, ovf=1. Signed -128*1 -> product=0xFF80, ovf=0.
4. Backpressure: hold out_ready=0 for 5 cycles after out_valid -> product/ovf stable and in_ready=0 throughout. Then raise out_ready together with in_valid carrying 7*9 -> same-edge handoff, next product=0x003F after 8 more edges.
5. Input stability: change a/b/is_signed while BUSY -> result reflects captured operands only. Assert in_valid during BUSY -> not accepted, in_ready=0.
6. Reset mid-BUSY (assert rst_n=0 at iteration 4, asynchronously between edges) -> out_valid=0, product=0, in_ready=1 after release. No stale result appears, and the next operation completes correctly.
